ahblite_irq_ctrl: RTL and testbench
===================================

# ahblite_irq_ctrl

AHB-Lite slave that collects single-cycle interrupt pulses from the timer and other peripherals. Each rising edge sets a per-source pending bit. The pending bits are masked by a software-written enable register and combined into one registered IRQ line for the Cortex-M0. It sits directly downstream of the timer: `timer_interrupt` is wired to `irq_src[0]`. The CPU reads the pending bits and clears them by write-1-to-clear.

## Interface
Parameters:
- N_SRC, default 4: number of interrupt sources, 1..16.

Ports:
- HCLK  in  1  system clock; all logic in this single domain.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  address; only [3:2] decoded.
- HTRANS  in  2  transfer type; a transfer is valid when HTRANS[1]=1.
- HSIZE  in  3  ignored; all accesses are treated as 32-bit.
- HPROT  in  4  ignored.
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data, sampled in the data phase.
- HREADY  in  1  bus ready.
- HREADYOUT  out  1  tied to 1; zero wait states.
- HRDATA  out  32  read data, combinational from the registered address.
- HRESP  out  1  tied to 0 (OKAY).
- irq_src  in  N_SRC  synchronous interrupt requests, level or pulse; bit 0 is `timer_interrupt`.
- irq_out  out  1  registered, active-high IRQ to the CPU.

## Operation
**Bus interface**
- Address phase: a transfer is accepted when HSEL & HREADY & HTRANS[1] = 1.
- On acceptance, the block registers HADDR[3:2], a write flag and a read flag.
- Data phase: a write takes effect on the HCLK edge that ends the data phase, using HWDATA.
- Back-to-back transfers are supported.

**Register map** (byte offsets)
- 0x0 PENDING
  - Read: pending[N_SRC-1:0], zero-extended.
  - Write: each 1 clears the matching pending bit; 0 bits have no effect.
- 0x4 ENABLE
  - Read/write: enable[N_SRC-1:0]. Upper bits are ignored on write and read as 0.
- 0x8 RAW
  - Read-only: current irq_src level. Writes are ignored.
- 0xC MISSED
  - Read: an 8-bit saturating count in [7:0]. It counts rising edges that arrived while that source's pending bit was already 1.
  - Write: any write clears it to 0.

**Edge detection**
- The block keeps a registered copy src_q of irq_src.
- rise[i] = irq_src[i] & ~src_q[i].

**Pending update, per bit, per edge**
- If rise: pending=1. Set wins over a simultaneous W1C.
- Else if W1C for this bit: pending=0.
- Else: hold.
- Enable does not gate setting; masked sources still latch pending.

**MISSED counter**
- Increments by 1 on any edge where at least one bit has rise & pending=1.
- Multiple simultaneous misses count as 1.
- Saturates at 0xFF.
- A write to 0xC in the same cycle as a miss: the clear wins, and the result is 0.

**IRQ output**
- irq_out is registered: irq_out <= |(pending & enable).

## Timing
**Reset values**
- pending=0, enable=0, MISSED=0, src_q=0, irq_out=0.
- Registered address and flags = 0.
- HRDATA = PENDING = 0.

**Latency**
- irq_src[i] rises before edge E → pending[i]=1 after E → irq_out=1 after E+1 (if enabled).
- A source that is high out of reset produces a rising edge on the first edge after reset releases.
- Write ENABLE in a data phase ending at edge E → enable updates at E → irq_out reflects the new mask after E+1.
- W1C at edge E → pending clears at E → irq_out deasserts after E+1, unless the source was re-set at E.

**Read timing and ordering**
- Read data reflects the register contents during the data phase. This includes a pending bit set at the edge that starts the data phase.
- Read-after-write to the same register returns the new value, with no bubble.

**Other rules**
- A level-high source sets pending once per rising edge. A held level does not re-set pending after a clear.
- Reset asserted mid-operation clears all state immediately and asynchronously; irq_out drops without waiting for a clock.

## Test plan
1. After reset, read 0x0/0x4/0x8/0xC → all 0; irq_out=0.
2. Write ENABLE=0x1; pulse irq_src[0] for 1 cycle at edge E → PENDING=0x1 after E, irq_out=1 after E+1. Write 0x0←0x1 → PENDING=0, irq_out=0 one edge later.
3. ENABLE=0; pulse irq_src[2] → PENDING=0x4, irq_out stays 0. Write ENABLE=0x4 → irq_out=1 one edge after the write.
4. Pulse irq_src[1] on the same edge as a W1C of bit 1 → PENDING bit 1 remains 1.
5. Pulse irq_src[0] 300 times without clearing → MISSED=0xFF. Write 0xC ← any value → MISSED=0.
6. Hold irq_src[3]=1, clear pending → pending stays 0 and RAW=0x8. Assert HRESETn=0 while irq_out=1 → irq_out=0 immediately.

Source files
------------

// File: rtl/ahblite_irq_ctrl.sv
// AHB-Lite interrupt collector: edge-detects irq_src into per-source pending
// bits (W1C), masks them with an enable register and drives a registered IRQ.
module ahblite_irq_ctrl #(
    parameter int N_SRC = 4
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic [2:0]       HSIZE,
    input  logic [3:0]       HPROT,
    input  logic             HWRITE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic             HREADYOUT,
    output logic [31:0]      HRDATA,
    output logic             HRESP,
    input  logic [N_SRC-1:0] irq_src,
    output logic             irq_out
);

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_RAW     = 2'd2;
    localparam logic [1:0] ADDR_MISSED  = 2'd3;

    logic [1:0]       addr_q, addr_d;
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic [N_SRC-1:0] src_q, src_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [7:0]       missed_q, missed_d;
    logic             irq_q, irq_d;

    logic             accept_s;
    logic [N_SRC-1:0] rise_s;
    logic [N_SRC-1:0] w1c_s;
    logic             miss_s;
    logic [31:0]      hrdata_s;
    logic             unused_s;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign irq_out   = irq_q;
    assign HRDATA    = hrdata_s;

    // Inputs that carry no meaning for this slave; folded so nothing dangles.
    assign unused_s = ^{HSIZE, HPROT, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA, rd_q};

    // Address-phase capture, edge detection and register next-state logic.
    always_comb begin
        accept_s = HSEL & HREADY & HTRANS[1];
        if (accept_s) begin
            addr_d = HADDR[3:2];
        end else begin
            addr_d = addr_q;
        end
        wr_d  = accept_s & HWRITE;
        rd_d  = accept_s & ~HWRITE;
        src_d = irq_src;

        rise_s = irq_src & ~src_q;
        miss_s = |(rise_s & pending_q);

        if (wr_q && (addr_q == ADDR_PENDING)) begin
            w1c_s = HWDATA[N_SRC-1:0];
        end else begin
            w1c_s = {N_SRC{1'b0}};
        end
        // A new edge wins over a simultaneous clear of the same bit.
        pending_d = (pending_q & ~w1c_s) | rise_s;

        if (wr_q && (addr_q == ADDR_ENABLE)) begin
            enable_d = HWDATA[N_SRC-1:0];
        end else begin
            enable_d = enable_q;
        end

        // Clear by write beats a coincident miss; otherwise saturate at 0xFF.
        if (wr_q && (addr_q == ADDR_MISSED)) begin
            missed_d = 8'h00;
        end else if (miss_s && (missed_q != 8'hFF)) begin
            missed_d = missed_q + 8'h01;
        end else begin
            missed_d = missed_q;
        end

        irq_d = |(pending_q & enable_q);
    end

    // Read mux driven from the registered address during the data phase.
    always_comb begin
        hrdata_s = 32'h0000_0000;
        case (addr_q)
            ADDR_PENDING: hrdata_s[N_SRC-1:0] = pending_q;
            ADDR_ENABLE:  hrdata_s[N_SRC-1:0] = enable_q;
            ADDR_RAW:     hrdata_s[N_SRC-1:0] = irq_src;
            ADDR_MISSED:  hrdata_s[7:0]       = missed_q;
            default:      hrdata_s            = 32'h0000_0000;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q    <= 2'd0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            src_q     <= {N_SRC{1'b0}};
            pending_q <= {N_SRC{1'b0}};
            enable_q  <= {N_SRC{1'b0}};
            missed_q  <= 8'h00;
            irq_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            src_q     <= src_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            missed_q  <= missed_d;
            irq_q     <= irq_d;
        end
    end

endmodule

// File: tb/tb_ahblite_irq_ctrl.sv
// Self-checking bench for ahblite_irq_ctrl with a cycle-level behavioural model.
module tb_ahblite_irq_ctrl;

    localparam int N = 4;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic [3:0]    HPROT;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic [31:0]   HRDATA;
    logic          HRESP;
    logic [N-1:0]  irq_src;
    logic          irq_out;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit       m_pend [N];
    bit       m_en   [N];
    bit       m_prev [N];
    int       m_missed;
    bit       m_irq;
    bit       m_dp_wr;
    int       m_dp_addr;

    ahblite_irq_ctrl #(.N_SRC(N)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .irq_src(irq_src), .irq_out(irq_out)
    );

    always #5 HCLK = ~HCLK;

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0; m_en[i] = 1'b0; m_prev[i] = 1'b0;
        end
        m_missed = 0; m_irq = 1'b0; m_dp_wr = 1'b0; m_dp_addr = 0;
    endtask

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < N; i++) begin
            if (a == 0) v[i] = m_pend[i];
            if (a == 1) v[i] = m_en[i];
            if (a == 2) v[i] = irq_src[i];
        end
        if (a == 3) v = m_missed;
        return v;
    endfunction

    // Advance one clock edge, updating the model from the pre-edge inputs.
    task automatic tick();
        bit np [N];
        bit ne [N];
        int nm;
        bit ni, miss, rise, nwr;
        int naddr;
        ni = 1'b0; miss = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && m_en[i]) ni = 1'b1;
            rise = irq_src[i] && !m_prev[i];
            if (rise && m_pend[i]) miss = 1'b1;
            if (rise) np[i] = 1'b1;
            else if (m_dp_wr && m_dp_addr == 0 && HWDATA[i]) np[i] = 1'b0;
            else np[i] = m_pend[i];
            ne[i] = (m_dp_wr && m_dp_addr == 1) ? HWDATA[i] : m_en[i];
        end
        nm = m_missed;
        if (miss && nm < 255) nm = nm + 1;
        if (m_dp_wr && m_dp_addr == 3) nm = 0;
        nwr   = HSEL && HREADY && HTRANS[1] && HWRITE;
        naddr = int'(HADDR[3:2]);
        @(posedge HCLK);
        #1;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = np[i]; m_en[i] = ne[i]; m_prev[i] = irq_src[i];
        end
        m_missed = nm; m_irq = ni; m_dp_wr = nwr; m_dp_addr = naddr;
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0;
    endtask

    // Single transfer: address phase, then data phase with an idle bus.
    task automatic xfer(input bit wr, input logic [3:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic [31:0] ex);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = {28'h0, a}; HWDATA = 32'h0;
        HSIZE = 3'($urandom); HPROT = 4'($urandom);
        tick();
        bus_idle();
        HADDR = $urandom;
        HWDATA = wd;
        rd = HRDATA;
        ex = model_read(int'(a[3:2]));
        tick();
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        bus_idle();
        HWDATA = 32'h0; HSIZE = 3'b010; HPROT = 4'h0; HREADY = 1'b1;
        #7;
        model_clear();
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    task automatic chk_irq(input string name);
        total++;
        if (irq_out !== m_irq) begin
            bad++;
            $display("FAIL %s: irq_out=%0b expected=%0b", name, irq_out, m_irq);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd, ex;
        irq_src = '0;
        do_reset();
        total++;
        if (irq_out !== 1'b0 || HRDATA !== 32'h0 || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: irq_out=%0b HRDATA=%h HREADYOUT=%0b HRESP=%0b expected 0/0/1/0",
                     irq_out, HRDATA, HREADYOUT, HRESP);
        end
        for (int a = 0; a < 4; a++) begin
            xfer(1'b0, 4'(a * 4), 32'h0, rd, ex);
            total++;
            if (rd !== 32'h0) begin
                bad++;
                $display("FAIL reset_read_%0d: got=%h expected=00000000", a * 4, rd);
            end
        end
        chk_irq("reset_irq");
    endtask

    task automatic test_irq_basic();
        logic [31:0] rd, ex;
        xfer(1'b1, 4'h4, 32'h1, rd, ex);
        irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        total++;
        if (irq_out !== 1'b0 || dut.HRDATA !== 32'h0 && 1'b0) begin
            bad++;
            $display("FAIL basic_irq_after_E: irq_out=%0b expected=0", irq_out);
        end
        tick();
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL basic_irq_after_E1: irq_out=%0b expected=1", irq_out);
        end
        xfer(1'b0, 4'h0, 32'h0, rd, ex);
        total++;
        if (rd !== 32'h1) begin
            bad++;
            $display("FAIL basic_pending: got=%h expected=00000001", rd);
        end
        xfer(1'b1, 4'h0, 32'h1, rd, ex);
        chk_irq("basic_irq_at_clear");
        tick();
        total++;
        if (irq_out !== 1'b0 || m_irq !== 1'b0) begin
            bad++;
            $display("FAIL basic_irq_cleared: irq_out=%0b expected=0", irq_out);
        end
        xfer(1'b0, 4'h0, 32'h0, rd, ex);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL basic_pending_cleared: got=%h expected=00000000", rd);
        end
    endtask

    task automatic test_mask();
        logic [31:0] rd, ex;
        xfer(1'b1, 4'h4, 32'h0, rd, ex);
        irq_src = 4'b0100;
        tick();
        irq_src = 4'b0000;
        tick();
        tick();
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL mask_irq_low: irq_out=%0b expected=0", irq_out);
        end
        xfer(1'b0, 4'h0, 32'h0, rd, ex);
        total++;
        if (rd !== 32'h4) begin
            bad++;
            $display("FAIL mask_pending: got=%h expected=00000004", rd);
        end
        xfer(1'b1, 4'h4, 32'hFFFF_FFF4, rd, ex);
        tick();
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL mask_irq_after_enable: irq_out=%0b expected=1", irq_out);
        end
        xfer(1'b0, 4'h4, 32'h0, rd, ex);
        total++;
        if (rd !== 32'h4) begin
            bad++;
            $display("FAIL mask_enable_readback: got=%h expected=00000004", rd);
        end
        xfer(1'b1, 4'h0, 32'hF, rd, ex);
    endtask

    task automatic test_set_wins();
        logic [31:0] rd, ex;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
        tick();
        bus_idle();
        HWDATA = 32'h2;
        irq_src = 4'b0010;
        tick();
        irq_src = 4'b0000;
        xfer(1'b0, 4'h0, 32'h0, rd, ex);
        total++;
        if (rd[1] !== 1'b1 || rd !== ex) begin
            bad++;
            $display("FAIL set_wins: got=%h expected=%h", rd, ex);
        end
        xfer(1'b1, 4'h0, 32'hF, rd, ex);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h4;
        tick();
        HWDATA = 32'h9; HWRITE = 1'b0; HADDR = 32'h4;
        tick();
        bus_idle();
        rd = HRDATA;
        total++;
        if (rd !== 32'h9) begin
            bad++;
            $display("FAIL back_to_back_raw: got=%h expected=00000009", rd);
        end
        tick();
    endtask

    task automatic test_missed_sat();
        logic [31:0] rd, ex;
        xfer(1'b1, 4'hC, 32'h0, rd, ex);
        for (int k = 0; k < 300; k++) begin
            irq_src = 4'b0001;
            tick();
            irq_src = 4'b0000;
            tick();
        end
        xfer(1'b0, 4'hC, 32'h0, rd, ex);
        total++;
        if (rd !== 32'hFF || rd !== ex) begin
            bad++;
            $display("FAIL missed_saturate: got=%h expected=000000ff", rd);
        end
        xfer(1'b1, 4'hC, 32'h1234_5678, rd, ex);
        xfer(1'b0, 4'hC, 32'h0, rd, ex);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL missed_clear: got=%h expected=00000000", rd);
        end
        xfer(1'b1, 4'h0, 32'hF, rd, ex);
    endtask

    task automatic test_level_and_reset();
        logic [31:0] rd, ex;
        xfer(1'b1, 4'h4, 32'h8, rd, ex);
        irq_src = 4'b1000;
        tick();
        xfer(1'b1, 4'h0, 32'h8, rd, ex);
        tick();
        tick();
        xfer(1'b0, 4'h0, 32'h0, rd, ex);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL level_no_reset: got=%h expected=00000000", rd);
        end
        xfer(1'b0, 4'h8, 32'h0, rd, ex);
        total++;
        if (rd !== 32'h8) begin
            bad++;
            $display("FAIL raw_read: got=%h expected=00000008", rd);
        end
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b1000;
        tick();
        tick();
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_irq: irq_out=%0b expected=1", irq_out);
        end
        #2;
        HRESETn = 1'b0;
        #1;
        total++;
        if (irq_out !== 1'b0 || HRDATA !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: irq_out=%0b HRDATA=%h expected 0/0", irq_out, HRDATA);
        end
        irq_src = 4'b0000;
        do_reset();
    endtask

    task automatic test_random();
        logic [31:0] rd, ex;
        int op;
        for (int k = 0; k < 80; k++) begin
            irq_src = N'($urandom);
            op = $urandom_range(0, 2);
            if (op == 0) begin
                tick();
            end else begin
                xfer(op == 1, 4'($urandom_range(0, 3) * 4), $urandom, rd, ex);
                if (op == 2) begin
                    total++;
                    if (rd !== ex) begin
                        bad++;
                        $display("FAIL random_read_%0d: got=%h expected=%h", k, rd, ex);
                    end
                end
            end
            chk_irq("random_irq");
        end
    endtask

    initial begin
        irq_src = '0;
        HWDATA  = 32'h0;
        test_reset();
        test_irq_basic();
        test_mask();
        test_set_wins();
        test_back_to_back();
        test_missed_sat();
        test_level_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
